rr_arbiter16: RTL and testbench

Round-robin arbiter that shares one 16-way resource (register-file write port, bus slot) among up to 16 requesters. Holds a grant until the owner signals completion or drops its request. Drives both a 4-bit grant index and a one-hot grant vector. It sits in front of the write-enable decode path, so exactly one requester drives the shared resource at a time.

---
 rtl/cpu_arb_pkg.sv | 32 +++
 rtl/rr_arbiter16_dec.sv | 15 +
 rtl/rr_arbiter16.sv | 124 ++++++++++++
 tb/tb_rr_arbiter16.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared arbitration types, sizes and the rotated priority search used by rr_arbiter16.
package cpu_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... with mod-16 wrap.
    function automatic logic [IDX_W:0] rr_first_set(input logic [N_REQ-1:0] req,
                                                    input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter16_dec.sv
// 4-to-16 one-hot decoder turning the grant index into a per-requester select line.
module Decoder4_16
    import cpu_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    // Pure one-hot decode of the index.
    always_comb begin
        onehot      = {N_REQ{1'b0}};
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with grant hold until Done or request drop.
// Optional forced revocation after HOLD_MAX cycles when RR_ARBITER16_TIMEOUT_EN is defined.
module rr_arbiter16
    import cpu_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [N_REQ-1:0] Req,
    input  logic             Done,
    output logic [N_REQ-1:0] Grant,
    output logic [IDX_W-1:0] GrantIdx,
    output logic             GrantValid,
    output logic             Timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter16: HOLD_MAX out of range 2..255");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [IDX_W:0]   pick_s;
    logic             release_s;
    logic [N_REQ-1:0] dec_s;

`ifdef RR_ARBITER16_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       expire_s;
`endif

    assign pick_s = rr_first_set(Req, ptr_q);

    // Next-state: grant selection in IDLE, release detection in BUSY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        release_s = Done || !Req[idx_q];
`ifdef RR_ARBITER16_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        expire_s  = (cnt_q == HOLD_LAST);
        release_s = release_s || expire_s;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_d = ARB_BUSY;
                    idx_d   = pick_s[IDX_W-1:0];
                    valid_d = 1'b1;
`ifdef RR_ARBITER16_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (release_s) begin
                    state_d   = ARB_IDLE;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 4'd1;
`ifdef RR_ARBITER16_TIMEOUT_EN
                    timeout_d = expire_s && !Done && Req[idx_q];
`endif
                end else begin
`ifdef RR_ARBITER16_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer and grant registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= 4'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
`ifdef RR_ARBITER16_TIMEOUT_EN
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
`ifdef RR_ARBITER16_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    Decoder4_16 u_dec (
        .idx    (idx_q),
        .onehot (dec_s)
    );

    assign Grant      = dec_s & {N_REQ{valid_q}};
    assign GrantIdx   = idx_q;
    assign GrantValid = valid_q;
`ifdef RR_ARBITER16_TIMEOUT_EN
    assign Timeout    = timeout_q;
`else
    assign Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed table-driven bench for rr_arbiter16, plus a hand-written hold/timeout sequence.
module tb_rr_arbiter16;

    logic        CLK;
    logic        Reset;
    logic [15:0] Req;
    logic        Done;
    logic [15:0] Grant;
    logic [3:0]  GrantIdx;
    logic        GrantValid;
    logic        Timeout;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        exp_v;
        logic [3:0]  exp_idx;
        logic [15:0] exp_g;
    } vec_t;

    vec_t vecs [28];

    rr_arbiter16 #(.HOLD_MAX(4)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Req        (Req),
        .Done       (Done),
        .Grant      (Grant),
        .GrantIdx   (GrantIdx),
        .GrantValid (GrantValid),
        .Timeout    (Timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] idx,
                             input logic [15:0] g, input logic to);
        check({tag, ".valid"}, {15'd0, GrantValid}, {15'd0, v});
        check({tag, ".idx"}, {12'd0, GrantIdx}, {12'd0, idx});
        check({tag, ".grant"}, Grant, g);
        check({tag, ".timeout"}, {15'd0, Timeout}, {15'd0, to});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        Req   = 16'h0000;
        Done  = 1'b0;

        //            rst   req       done  v     idx    grant
        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[6]  = '{1'b0, 16'h0024, 1'b0, 1'b1, 4'd2,  16'h0004};
        vecs[7]  = '{1'b0, 16'h0024, 1'b1, 1'b0, 4'd2,  16'h0000};
        vecs[8]  = '{1'b0, 16'h0024, 1'b0, 1'b1, 4'd5,  16'h0020};
        vecs[9]  = '{1'b0, 16'h0024, 1'b1, 1'b0, 4'd5,  16'h0000};
        vecs[10] = '{1'b0, 16'h8000, 1'b0, 1'b1, 4'd15, 16'h8000};
        vecs[11] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 16'h0000};
        vecs[12] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd0,  16'h0001};
        vecs[13] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd0,  16'h0000};
        vecs[14] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd15, 16'h8000};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd15, 16'h0000};
        vecs[16] = '{1'b0, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008};
        vecs[17] = '{1'b0, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008};
        vecs[18] = '{1'b0, 16'h0080, 1'b0, 1'b0, 4'd3,  16'h0000};
        vecs[19] = '{1'b0, 16'h0080, 1'b0, 1'b1, 4'd7,  16'h0080};
        vecs[20] = '{1'b0, 16'h0080, 1'b1, 1'b0, 4'd7,  16'h0000};
        vecs[21] = '{1'b0, 16'h0030, 1'b0, 1'b1, 4'd4,  16'h0010};
        vecs[22] = '{1'b1, 16'h0030, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[23] = '{1'b0, 16'h0003, 1'b0, 1'b1, 4'd0,  16'h0001};
        vecs[24] = '{1'b0, 16'h0002, 1'b1, 1'b0, 4'd0,  16'h0000};
        vecs[25] = '{1'b0, 16'h0003, 1'b0, 1'b1, 4'd1,  16'h0002};
        vecs[26] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd1,  16'h0000};
        vecs[27] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1,  16'h0000};

        for (int i = 0; i < 28; i++) begin
            Reset = vecs[i].rst;
            Req   = vecs[i].req;
            Done  = vecs[i].done;
            @(posedge CLK);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_idx, vecs[i].exp_g, 1'b0);
        end

        // Hold with Done low: idle pointer is 2, only requester 4 active.
        Reset = 1'b0;
        Req   = 16'h0010;
        Done  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            check_all($sformatf("hold%0d", k), 1'b1, 4'd4, 16'h0010, 1'b0);
        end
        @(posedge CLK);
        #1;
`ifdef RR_ARBITER16_TIMEOUT_EN
        check_all("revoke", 1'b0, 4'd4, 16'h0000, 1'b1);
`else
        check_all("revoke", 1'b1, 4'd4, 16'h0010, 1'b0);
`endif
        @(posedge CLK);
        #1;
        check_all("regrant", 1'b1, 4'd4, 16'h0010, 1'b0);

        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check_all("final_reset", 1'b0, 4'd0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
